// File: rtl/axi_slv_mem_if.sv
// AXI3 channel bundle for the slave memory model.
// The slave modport is the memory side; the master modport is the bench or agent side.
interface axi_slv_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [ID_WIDTH-1:0]     wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_slv_mem.sv
// AXI3 slave memory: independent write and read FSMs over a byte-strobed word array.
// Every channel transfers on a cycle where valid and ready are both high; a valid once raised holds its payload until that cycle.
module axi_slv_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic       aclk,
    input  logic       aresetn,
    axi_slv_mem_if.slave bus,
    output logic [1:0] dbg_wstate_o,
    output logic [1:0] dbg_rstate_o
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_DATA} rstate_e;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size,
        input logic [7:0] len, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] sz, bnd, lower;
        sz    = ADDR_WIDTH'(1) << size;
        bnd   = sz * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
        lower = addr & ~(bnd - ADDR_WIDTH'(1));
        // Legal WRAP boundaries are powers of two, so the modulo is a mask.
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = lower + ((addr + sz - lower) & (bnd - ADDR_WIDTH'(1)));
            default: next_addr = (addr & ~(sz - ADDR_WIDTH'(1))) + sz;
        endcase
    endfunction

    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len,
                                       input logic [2:0] size);
        burst_bad = (burst == 2'b11) ||
                    ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                    (int'(size) > OFF_W);
    endfunction

    function automatic logic idx_bad(input logic [ADDR_WIDTH-1:0] addr);
        idx_bad = (addr >> OFF_W) >= ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        word_idx = IDX_W'(addr >> OFF_W);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;
    logic    rst_done_q;

    logic [ID_WIDTH-1:0]   awid_q, arid_q;
    logic [ADDR_WIDTH-1:0] waddr_q, raddr_q;
    logic [7:0]            wlen_q, wcnt_q, rlen_q, rcnt_q;
    logic [2:0]            wsize_q, rsize_q;
    logic [1:0]            wburst_q, rburst_q;
    logic                  wbad_q, werr_q, rbad_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic aw_hs, w_hs, ar_hs, r_hs;
    logic w_last_beat, w_beat_err, wr_en, r_last_beat, ar_err, rn_err;
    logic [ADDR_WIDTH-1:0] r_next_addr;

    assign aw_hs       = bus.awvalid && bus.awready;
    assign w_hs        = bus.wvalid && bus.wready;
    assign ar_hs       = bus.arvalid && bus.arready;
    assign r_hs        = bus.rvalid && bus.rready;
    assign w_last_beat = (wcnt_q == wlen_q);
    assign r_last_beat = (rcnt_q == rlen_q);
    assign w_beat_err  = wbad_q || idx_bad(waddr_q) || (bus.wid != awid_q) ||
                         (bus.wlast != w_last_beat);
    // A beat arriving in a reset cycle is dropped along with the burst.
    assign wr_en       = w_hs && !w_beat_err && aresetn;
    assign r_next_addr = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
    assign ar_err      = burst_bad(bus.arburst, bus.arlen, bus.arsize) || idx_bad(bus.araddr);
    assign rn_err      = rbad_q || idx_bad(r_next_addr);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wstate_q   <= W_IDLE;
            rstate_q   <= R_IDLE;
            rst_done_q <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            rst_done_q <= 1'b1;
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:  if (aw_hs) wstate_d = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) wstate_d = W_RESP;
            W_RESP:  if (bus.bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Ready outputs wait for rst_done_q so they stay low through the reset cycle.
    always_comb begin
        bus.awready  = (wstate_q == W_IDLE) && rst_done_q;
        bus.wready   = (wstate_q == W_DATA);
        bus.bvalid   = (wstate_q == W_RESP);
        bus.bid      = awid_q;
        bus.bresp    = ((wstate_q == W_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;
        bus.arready  = (rstate_q == R_IDLE) && rst_done_q;
        bus.rvalid   = (rstate_q == R_DATA);
        bus.rid      = arid_q;
        bus.rdata    = rdata_q;
        bus.rresp    = rresp_q;
        bus.rlast    = (rstate_q == R_DATA) && r_last_beat;
        dbg_wstate_o = wstate_q;
        dbg_rstate_o = rstate_q;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            awid_q   <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wsize_q  <= '0;
            wburst_q <= '0;
            wcnt_q   <= '0;
            wbad_q   <= 1'b0;
            werr_q   <= 1'b0;
        end else if (aw_hs) begin
            awid_q   <= bus.awid;
            waddr_q  <= bus.awaddr;
            wlen_q   <= bus.awlen;
            wsize_q  <= bus.awsize;
            wburst_q <= bus.awburst;
            wcnt_q   <= '0;
            wbad_q   <= burst_bad(bus.awburst, bus.awlen, bus.awsize);
            werr_q   <= 1'b0;
        end else if (w_hs) begin
            waddr_q  <= next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
            wcnt_q   <= wcnt_q + 8'd1;
            if (w_beat_err) werr_q <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (bus.wstrb[i]) mem_q[word_idx(waddr_q)][i*8 +: 8] <= bus.wdata[i*8 +: 8];
            end
        end
    end

    // Read data is registered from the array before any same-cycle write lands.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            arid_q   <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rcnt_q   <= '0;
            rbad_q   <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            arid_q   <= bus.arid;
            raddr_q  <= bus.araddr;
            rlen_q   <= bus.arlen;
            rsize_q  <= bus.arsize;
            rburst_q <= bus.arburst;
            rcnt_q   <= '0;
            rbad_q   <= burst_bad(bus.arburst, bus.arlen, bus.arsize);
            rdata_q  <= ar_err ? '0 : mem_q[word_idx(bus.araddr)];
            rresp_q  <= ar_err ? RESP_SLVERR : RESP_OKAY;
        end else if (r_hs && !r_last_beat) begin
            raddr_q  <= r_next_addr;
            rcnt_q   <= rcnt_q + 8'd1;
            rdata_q  <= rn_err ? '0 : mem_q[word_idx(r_next_addr)];
            rresp_q  <= rn_err ? RESP_SLVERR : RESP_OKAY;
        end
    end
endmodule
